// File: rtl/jk_reg_bank_if.sv
// Handshake bundle for jk_reg_bank: control/data toward the bank, state back out.
interface jk_reg_bank_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic             tc;
    logic             changed;

    // Driver side (controller / testbench)
    modport master (
        output en, mode, j, k, d,
        input  q, qn, tc, changed
    );

    // Register bank side
    modport slave (
        input  en, mode, j, k, d,
        output q, qn, tc, changed
    );
endinterface

// File: rtl/jk_reg_bank.sv
// jk_reg_bank: WIDTH-bit bank of rising-edge JK flip-flops with global enable,
// parallel load and up/down counting built from JK toggle chains.
// Asynchronous active-high reset to RESET_VAL.

// One JK cell. Counting is expressed as a toggle (J=K=carry) so the same cell
// serves JK, load and count modes.
module jk_reg_bit #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] mode_i,
    input  logic       j_i,
    input  logic       k_i,
    input  logic       d_i,
    input  logic       up_carry_i,   // all lower bits are 1
    input  logic       dn_carry_i,   // all lower bits are 0
    output logic       q_o,
    output logic       nxt_o
);
    localparam logic [1:0] M_JK   = 2'b00;
    localparam logic [1:0] M_LOAD = 2'b01;
    localparam logic [1:0] M_UP   = 2'b10;

    logic q_q;
    logic q_d;

    // Next-state selection; inputs outside their mode never reach q_d
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            case (mode_i)
                M_JK: begin
                    case ({j_i, k_i})
                        2'b01:   q_d = 1'b0;
                        2'b10:   q_d = 1'b1;
                        2'b11:   q_d = ~q_q;
                        default: q_d = q_q;
                    endcase
                end
                M_LOAD:  q_d = d_i;
                M_UP:    q_d = q_q ^ up_carry_i;
                default: q_d = q_q ^ dn_carry_i;
            endcase
        end
    end

    // State flop, async reset to this bit's reset value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= RST_BIT;
        else     q_q <= q_d;
    end

    assign q_o   = q_q;
    assign nxt_o = q_d;
endmodule

module jk_reg_bank #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    jk_reg_bank_if.slave bus
);
    localparam logic [1:0] M_UP = 2'b10;
    localparam logic [1:0] M_DN = 2'b11;

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] nxt_w;
    logic [WIDTH-1:0] up_c;
    logic [WIDTH-1:0] dn_c;
    logic             changed_q;
    logic             changed_d;

    // Ripple carry chains: bit i toggles when everything below it is all-1 (up)
    // or all-0 (down); bit 0 always toggles.
    assign up_c[0] = 1'b1;
    assign dn_c[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_carry
        assign up_c[i] = up_c[i-1] &  q_w[i-1];
        assign dn_c[i] = dn_c[i-1] & ~q_w[i-1];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_reg_bit #(
            .RST_BIT (RESET_VAL[i])
        ) u_bit (
            .clk        (clk),
            .rst        (rst),
            .en_i       (bus.en),
            .mode_i     (bus.mode),
            .j_i        (bus.j[i]),
            .k_i        (bus.k[i]),
            .d_i        (bus.d[i]),
            .up_carry_i (up_c[i]),
            .dn_carry_i (dn_c[i]),
            .q_o        (q_w[i]),
            .nxt_o      (nxt_w[i])
        );
    end

    // A disabled edge forces next==current, so this also clears on en=0
    assign changed_d = (nxt_w != q_w);

    // One-cycle flag marking an edge that altered q
    always_ff @(posedge clk or posedge rst) begin
        if (rst) changed_q <= 1'b0;
        else     changed_q <= changed_d;
    end

    assign bus.q       = q_w;
    assign bus.qn      = ~q_w;
    assign bus.changed = changed_q;
    // Terminal count is purely a function of mode and q; enable is ignored
    assign bus.tc      = ((bus.mode == M_UP) && (&q_w)) ||
                         ((bus.mode == M_DN) && ~(|q_w));
endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank (WIDTH=4, RESET_VAL=4'b1010).
// Stimulus pushes the expected state whenever outputs should be settled;
// an independent monitor pops and compares one time unit later.
module tb_jk_reg_bank;
    localparam int         W  = 4;
    localparam logic [3:0] RV = 4'b1010;

    typedef struct {
        logic [3:0] q;
        logic       chg;
        logic       tc;
        string      tag;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   checks;
    int   fails;

    jk_reg_bank_if #(.WIDTH(W)) bus ();

    jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    // Monitor: whenever an expectation is queued, sample shortly after and compare
    initial begin
        exp_t e;
        forever begin
            wait (sb.size() != 0);
            #1;
            e = sb.pop_front();
            cmp({e.tag, ".q"},       bus.q,                 e.q);
            cmp({e.tag, ".qn"},      bus.qn,                ~e.q);
            cmp({e.tag, ".changed"}, {3'b0, bus.changed},   {3'b0, e.chg});
            cmp({e.tag, ".tc"},      {3'b0, bus.tc},        {3'b0, e.tc});
        end
    end

    task automatic push(input logic [3:0] q, input logic chg, input logic tc, input string tag);
        exp_t e;
        e.q = q; e.chg = chg; e.tc = tc; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic drive(input logic en, input logic [1:0] mode,
                         input logic [3:0] j, input logic [3:0] k, input logic [3:0] d);
        bus.en = en; bus.mode = mode; bus.j = j; bus.k = k; bus.d = d;
    endtask

    // Wait one rising edge, queue the expected post-edge state, return at negedge+1
    task automatic tick(input logic [3:0] q, input logic chg, input logic tc, input string tag);
        @(posedge clk);
        push(q, chg, tc, tag);
        @(negedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b1;
        drive(1'b0, 2'b00, 4'h0, 4'h0, 4'h0);
        #2;
        push(RV, 1'b0, 1'b0, "reset_init");
        @(negedge clk); #1;
        rst = 1'b0;

        // JK truth table, starting from 0000
        drive(1'b1, 2'b01, 4'h0, 4'h0, 4'b0000);
        tick(4'b0000, 1'b1, 1'b0, "load0");
        drive(1'b1, 2'b00, 4'b1100, 4'b1010, 4'hF);
        tick(4'b1100, 1'b1, 1'b0, "jk_mix");      // toggle,set,clear,hold
        drive(1'b1, 2'b00, 4'b0000, 4'b0000, 4'hF);
        tick(4'b1100, 1'b0, 1'b0, "jk_hold");
        drive(1'b1, 2'b00, 4'b1111, 4'b1111, 4'h0);
        tick(4'b0011, 1'b1, 1'b0, "jk_toggle");

        // Parallel load and enable
        drive(1'b1, 2'b01, 4'h0, 4'h0, 4'b0110);
        tick(4'b0110, 1'b1, 1'b0, "load");
        drive(1'b0, 2'b01, 4'hF, 4'hF, 4'b1111);
        tick(4'b0110, 1'b0, 1'b0, "en0_a");
        tick(4'b0110, 1'b0, 1'b0, "en0_b");
        drive(1'b1, 2'b01, 4'h0, 4'h0, 4'b0110);
        tick(4'b0110, 1'b0, 1'b0, "reload_same");

        // Up-count wrap
        drive(1'b1, 2'b01, 4'h0, 4'h0, 4'b1101);
        tick(4'b1101, 1'b1, 1'b0, "load1101");
        drive(1'b1, 2'b10, 4'hF, 4'h0, 4'h0);
        tick(4'b1110, 1'b1, 1'b0, "up1");
        tick(4'b1111, 1'b1, 1'b1, "up2");
        tick(4'b0000, 1'b1, 1'b0, "up_wrap");
        tick(4'b0001, 1'b1, 1'b0, "up4");

        // Down-count wrap and mode switch
        drive(1'b1, 2'b11, 4'h0, 4'hF, 4'hF);
        tick(4'b0000, 1'b1, 1'b1, "dn1");
        tick(4'b1111, 1'b1, 1'b0, "dn_wrap");
        drive(1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
        tick(4'b0000, 1'b1, 1'b0, "switch_up");
        // tc with enable low
        drive(1'b0, 2'b11, 4'h0, 4'h0, 4'h0);
        tick(4'b0000, 1'b0, 1'b1, "tc_en0");

        // Async reset between edges, then held across edges while counting
        rst = 1'b1;
        push(RV, 1'b0, 1'b0, "async_rst");
        @(negedge clk); #1;
        drive(1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
        tick(RV, 1'b0, 1'b0, "rst_hold1");
        tick(RV, 1'b0, 1'b0, "rst_hold2");
        tick(RV, 1'b0, 1'b0, "rst_hold3");
        rst = 1'b0;
        tick(4'b1011, 1'b1, 1'b0, "post_rst_up");

        // Reset pulse mid-count at q=0111
        drive(1'b1, 2'b01, 4'h0, 4'h0, 4'b0110);
        tick(4'b0110, 1'b1, 1'b0, "load0110");
        drive(1'b1, 2'b10, 4'h0, 4'h0, 4'h0);
        tick(4'b0111, 1'b1, 1'b0, "up0111");
        rst = 1'b1;
        push(RV, 1'b0, 1'b0, "mid_rst");
        #3;
        rst = 1'b0;
        tick(4'b1011, 1'b1, 1'b0, "mid_rst_up");

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
